rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
Parametrised next-generation reservation station for the out-of-order core. It sits between the issue stage and one execution unit and buffers renamed ALU ops until both operands are valid. It snoops NUM_CDB result buses, including a bypass for ops issued in the same cycle. It dispatches the oldest ready entry through a valid/ready handshake, so the execution unit can stall it.

Parameters:
RS_DEPTH, 16, number of entries (power of 2, at least 2)
NUM_CDB, 2, number of result broadcast ports
XLEN, 32, operand/imm/pc width
ROB_IDX_W, 4, ROB tag width
OP_W, 6, op-type encoding width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
flush  in  1  misprediction flush
issue_valid  in  1  allocate one entry this cycle
issue_op  in  OP_W  op type
issue_vj, issue_vk  in  XLEN  operand values
issue_qj, issue_qk  in  ROB_IDX_W  producer tags
issue_rj, issue_rk  in  1  operand ready flags
issue_imm, issue_pc  in  XLEN  immediate, instruction pc
issue_robid  in  ROB_IDX_W  destination tag
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_value  in  NUM_CDB*XLEN  packed values; port p at [p*XLEN +: XLEN]
cdb_robid  in  NUM_CDB*ROB_IDX_W  packed tags
out_valid  out  1  dispatch valid
out_ready  in  1  execution unit accepts
out_op, out_vj, out_vk, out_imm, out_pc, out_robid  out  various  dispatched fields
next_full  out  1  issue must stall next cycle
occupancy  out  clog2(RS_DEPTH)+1  busy entry count

Behaviour:
- Reset/flush: rst or flush (same cycle, highest priority) clears every busy, rj, rk and age bit. out_valid=0, occupancy=0, next_full=0. The other out_* fields are don't-care (0 on rst).
- rdy=0: no state changes. Outputs hold.
- Allocation: the issued op goes into the lowest-index free entry.
- Issue bypass (new behaviour): if issue_rj=0 and some valid CDB port has tag issue_qj, store that value with rj=1. The same rule applies to k.
- Issue while no entry is free is a protocol error: ignore the issue and flag it in simulation.
- Wakeup: for each busy entry and each operand with r=0, a matching valid CDB tag sets r=1 and captures the value.
  - If multiple ports carry the same tag, the lowest port index wins.
  - An entry woken in cycle N is dispatch-eligible at the cycle N+1 edge, so dispatch latency is at least 1 cycle after wakeup or allocation.
- Select: among busy entries with rj&rk, choose the oldest by allocation order, held in an RS_DEPTH×RS_DEPTH age matrix. Age is updated on allocate and cleared on free.
- Dispatch handshake:
  - The output register loads when a ready entry exists and (!out_valid || out_ready).
  - On load the selected entry is freed in the same edge.
  - If no candidate exists and out_ready=1, out_valid drops to 0.
  - While out_valid=1 and out_ready=0, all out_* fields are stable.
- Simultaneous allocate and free in one edge are allowed. An entry freed this edge is not reused until the next cycle.
- occupancy: registered busy count.
- next_full: combinational, occupancy + issue_valid − free_this_cycle ≥ RS_DEPTH.
- Operands captured by CDB on the dispatch edge are not forwarded into the output register. Selection uses registered ready bits only.

Decomposition:
- Shared constants include: op encodings, ROB_IDX_W default, and the CDB packing macros.
- One natural sub-module: rs_age_select, which takes the RS_DEPTH request vector and returns a one-hot grant of the oldest requester. It contains the age matrix with allocate/free inputs.
- Entry storage and wakeup stay in the top module.

Test Plan:
1. Issue ADD with rj=rk=1, out_ready=1 → out_valid=1 on the next edge with matching fields; occupancy returns to 0.
2. Issue op with qj=3, rj=0; two cycles later CDB port1 broadcasts tag 3, value 0x55 → op dispatches the cycle after, with out_vj=0x55.
3. Issue op with qk=5 in the same cycle CDB port0 broadcasts tag 5, value 0xA0 → entry ready immediately and dispatches the next cycle with out_vk=0xA0.
4. Issue entries A, B, C, all ready, with out_ready=0 for 3 cycles → A is held on outputs, stable. After out_ready rises, dispatch order is A, B, C.
5. Fill RS_DEPTH entries with unready ops → next_full asserts as the last is issued. Broadcasting one tag frees one entry and deasserts next_full.
6. Assert flush mid-stream with 5 busy entries and out_valid=1 → next cycle occupancy=0, out_valid=0, and later CDB broadcasts cause no dispatch.

Source files
------------

// File: rtl/rs_multi_cdb_pkg.sv
// rtl/rs_multi_cdb_pkg.sv - shared constants and CDB packing helper for the reservation station
package rs_multi_cdb_pkg;

  localparam int DEF_RS_DEPTH  = 16;
  localparam int DEF_NUM_CDB   = 2;
  localparam int DEF_XLEN      = 32;
  localparam int DEF_ROB_IDX_W = 4;
  localparam int DEF_OP_W      = 6;

  // ALU op encodings carried through the station untouched
  localparam logic [DEF_OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 6'd1;
  localparam logic [DEF_OP_W-1:0] OP_AND = 6'd2;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 6'd3;
  localparam logic [DEF_OP_W-1:0] OP_XOR = 6'd4;

  // LSB of CDB port p inside a packed bus of w-bit fields
  function automatic int cdb_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - age matrix picking the oldest requesting entry
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DEPTH-1:0] alloc_oh_i,
  input  logic [DEPTH-1:0] free_oh_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  // age_q[i][j] set means entry i was allocated before entry j
  logic [DEPTH-1:0] age_q [DEPTH];

  // A new entry is younger than every other; a freed entry loses its seniority
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_oh_i[i])      age_q[i][j] <= 1'b0;
          else if (alloc_oh_i[j]) age_q[i][j] <= 1'b1;
          else if (free_oh_i[i])  age_q[i][j] <= 1'b0;
        end
      end
    end
  end

  // Grant a requester that no other requester is older than
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && age_q[j][i]) older = 1'b1;
      end
      grant_o[i] = req_i[i] && !older;
    end
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// rtl/rs_multi_cdb.sv - reservation station with multi-port CDB snoop and oldest-first dispatch
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int RS_DEPTH  = DEF_RS_DEPTH,
  parameter int NUM_CDB   = DEF_NUM_CDB,
  parameter int XLEN      = DEF_XLEN,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W,
  parameter int OP_W      = DEF_OP_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           flush,
  input  logic                           issue_valid,
  input  logic [OP_W-1:0]                issue_op,
  input  logic [XLEN-1:0]                issue_vj,
  input  logic [XLEN-1:0]                issue_vk,
  input  logic [ROB_IDX_W-1:0]           issue_qj,
  input  logic [ROB_IDX_W-1:0]           issue_qk,
  input  logic                           issue_rj,
  input  logic                           issue_rk,
  input  logic [XLEN-1:0]                issue_imm,
  input  logic [XLEN-1:0]                issue_pc,
  input  logic [ROB_IDX_W-1:0]           issue_robid,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*XLEN-1:0]        cdb_value,
  input  logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_robid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OP_W-1:0]                out_op,
  output logic [XLEN-1:0]                out_vj,
  output logic [XLEN-1:0]                out_vk,
  output logic [XLEN-1:0]                out_imm,
  output logic [XLEN-1:0]                out_pc,
  output logic [ROB_IDX_W-1:0]           out_robid,
  output logic                           next_full,
  output logic [$clog2(RS_DEPTH):0]      occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]  busy_q, rj_q, rk_q;
  logic [OP_W-1:0]      op_q    [RS_DEPTH];
  logic [XLEN-1:0]      vj_q    [RS_DEPTH];
  logic [XLEN-1:0]      vk_q    [RS_DEPTH];
  logic [XLEN-1:0]      imm_q   [RS_DEPTH];
  logic [XLEN-1:0]      pc_q    [RS_DEPTH];
  logic [ROB_IDX_W-1:0] qj_q    [RS_DEPTH];
  logic [ROB_IDX_W-1:0] qk_q    [RS_DEPTH];
  logic [ROB_IDX_W-1:0] robid_q [RS_DEPTH];
  logic [CNT_W-1:0]     occ_q;

  logic [RS_DEPTH-1:0]  wk_j_hit, wk_k_hit;
  logic [XLEN-1:0]      wk_j_val [RS_DEPTH];
  logic [XLEN-1:0]      wk_k_val [RS_DEPTH];
  logic                 byp_j_hit, byp_k_hit;
  logic [XLEN-1:0]      byp_j_val, byp_k_val;
  logic                 have_free, do_alloc, load;
  logic [IDX_W-1:0]     alloc_idx, sel_idx;
  logic [RS_DEPTH-1:0]  alloc_oh, free_oh, req, grant;
  logic [CNT_W:0]       nf_sum;

  // Tag match against every CDB port; descending scan lets the lowest port win
  always_comb begin
    wk_j_hit  = '0;
    wk_k_hit  = '0;
    byp_j_hit = 1'b0;
    byp_k_hit = 1'b0;
    byp_j_val = '0;
    byp_k_val = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk_j_val[i] = '0;
      wk_k_val[i] = '0;
    end
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        if (cdb_robid[cdb_lsb(p, ROB_IDX_W) +: ROB_IDX_W] == issue_qj) begin
          byp_j_hit = 1'b1;
          byp_j_val = cdb_value[cdb_lsb(p, XLEN) +: XLEN];
        end
        if (cdb_robid[cdb_lsb(p, ROB_IDX_W) +: ROB_IDX_W] == issue_qk) begin
          byp_k_hit = 1'b1;
          byp_k_val = cdb_value[cdb_lsb(p, XLEN) +: XLEN];
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (cdb_robid[cdb_lsb(p, ROB_IDX_W) +: ROB_IDX_W] == qj_q[i]) begin
            wk_j_hit[i] = 1'b1;
            wk_j_val[i] = cdb_value[cdb_lsb(p, XLEN) +: XLEN];
          end
          if (cdb_robid[cdb_lsb(p, ROB_IDX_W) +: ROB_IDX_W] == qk_q[i]) begin
            wk_k_hit[i] = 1'b1;
            wk_k_val[i] = cdb_value[cdb_lsb(p, XLEN) +: XLEN];
          end
        end
      end
    end
  end

  // Lowest-index free slot, judged on registered busy so a slot freed this edge is not reused
  always_comb begin
    alloc_idx = '0;
    have_free = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_idx = IDX_W'(i);
        have_free = 1'b1;
      end
    end
  end

  // Encode the one-hot grant into a slot index for the output mux
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  assign do_alloc = rdy && issue_valid && have_free;
  assign alloc_oh = do_alloc ? (RS_DEPTH'(1) << alloc_idx) : '0;
  assign req      = busy_q & rj_q & rk_q;
  assign load     = rdy && (|req) && (!out_valid || out_ready);
  assign free_oh  = load ? grant : '0;

  rs_age_select #(.DEPTH(RS_DEPTH)) u_age (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (flush),
    .en_i       (rdy),
    .alloc_oh_i (alloc_oh),
    .free_oh_i  (free_oh),
    .req_i      (req),
    .grant_o    (grant)
  );

  // Entry storage: free on dispatch, wake on CDB match, fill on allocate
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q <= '0;
      rj_q   <= '0;
      rk_q   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (free_oh[i]) busy_q[i] <= 1'b0;
        if (busy_q[i] && !rj_q[i] && wk_j_hit[i]) begin
          rj_q[i] <= 1'b1;
          vj_q[i] <= wk_j_val[i];
        end
        if (busy_q[i] && !rk_q[i] && wk_k_hit[i]) begin
          rk_q[i] <= 1'b1;
          vk_q[i] <= wk_k_val[i];
        end
        if (alloc_oh[i]) begin
          busy_q[i]  <= 1'b1;
          op_q[i]    <= issue_op;
          imm_q[i]   <= issue_imm;
          pc_q[i]    <= issue_pc;
          robid_q[i] <= issue_robid;
          qj_q[i]    <= issue_qj;
          qk_q[i]    <= issue_qk;
          rj_q[i]    <= issue_rj || byp_j_hit;
          rk_q[i]    <= issue_rk || byp_k_hit;
          vj_q[i]    <= (!issue_rj && byp_j_hit) ? byp_j_val : issue_vj;
          vk_q[i]    <= (!issue_rk && byp_k_hit) ? byp_k_val : issue_vk;
        end
      end
    end
  end

  // Dispatch register: loads when empty or drained, holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_vj    <= '0;
      out_vk    <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_robid <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (rdy) begin
      if (load) begin
        out_valid <= 1'b1;
        out_op    <= op_q[sel_idx];
        out_vj    <= vj_q[sel_idx];
        out_vk    <= vk_q[sel_idx];
        out_imm   <= imm_q[sel_idx];
        out_pc    <= pc_q[sel_idx];
        out_robid <= robid_q[sel_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Busy count tracks allocations minus dispatches
  always_ff @(posedge clk) begin
    if (rst || flush) occ_q <= '0;
    else if (rdy)     occ_q <= occ_q + CNT_W'(do_alloc) - CNT_W'(load);
  end

  assign occupancy = occ_q;
  assign nf_sum    = {1'b0, occ_q} + (CNT_W+1)'(issue_valid) - (CNT_W+1)'(load);
  assign next_full = nf_sum >= (CNT_W+1)'(RS_DEPTH);

  a_issue_when_full: assert property (@(posedge clk) disable iff (rst || flush)
    (rdy && issue_valid) |-> have_free);

endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb/tb_rs_multi_cdb.sv - randomized and directed bench against a queue model of the station
module tb_rs_multi_cdb;
  import rs_multi_cdb_pkg::*;

  localparam int D  = 16;
  localparam int NC = 2;
  localparam int XL = 32;
  localparam int RW = 4;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst, rdy, flush, issue_valid, issue_rj, issue_rk, out_ready;
  logic [OW-1:0] issue_op, out_op;
  logic [XL-1:0] issue_vj, issue_vk, issue_imm, issue_pc;
  logic [RW-1:0] issue_qj, issue_qk, issue_robid, out_robid;
  logic [NC-1:0] cdb_valid;
  logic [NC*XL-1:0] cdb_value;
  logic [NC*RW-1:0] cdb_robid;
  logic out_valid, next_full;
  logic [XL-1:0] out_vj, out_vk, out_imm, out_pc;
  logic [$clog2(D):0] occupancy;

  always #5 clk = ~clk;

  rs_multi_cdb #(.RS_DEPTH(D), .NUM_CDB(NC), .XLEN(XL), .ROB_IDX_W(RW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_robid(issue_robid),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_robid(cdb_robid),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_vj(out_vj),
    .out_vk(out_vk), .out_imm(out_imm), .out_pc(out_pc), .out_robid(out_robid),
    .next_full(next_full), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [OW-1:0] op;
    logic [XL-1:0] vj, vk, imm, pc;
    logic [RW-1:0] qj, qk, robid;
    logic          rj, rk;
  } ent_t;

  // Model: entries kept in allocation order, oldest at the front
  ent_t mq[$];
  ent_t m_out;
  logic m_ov;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic cdb_match(input logic [RW-1:0] tag, output logic [XL-1:0] val);
    val = '0;
    for (int p = 0; p < NC; p++) begin
      if (cdb_valid[p] && cdb_robid[p*RW +: RW] == tag) begin
        val = cdb_value[p*XL +: XL];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic ent_t wake(input ent_t e);
    logic [XL-1:0] v;
    logic hit;
    hit = cdb_match(e.qj, v);
    if (!e.rj && hit) begin e.rj = 1'b1; e.vj = v; end
    hit = cdb_match(e.qk, v);
    if (!e.rk && hit) begin e.rk = 1'b1; e.vk = v; end
    return e;
  endfunction

  function automatic int cand_idx();
    for (int i = 0; i < mq.size(); i++) if (mq[i].rj && mq[i].rk) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int c;
    int n0;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_ov = 1'b0;
      if (rst) m_out = '0;
    end else if (rdy) begin
      n0 = mq.size();
      c  = cand_idx();
      if (c >= 0 && (!m_ov || out_ready)) begin
        m_out = mq[c];
        m_ov  = 1'b1;
        mq.delete(c);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (issue_valid && n0 < D) begin
        e = '{op: issue_op, vj: issue_vj, vk: issue_vk, imm: issue_imm, pc: issue_pc,
              qj: issue_qj, qk: issue_qk, robid: issue_robid, rj: issue_rj, rk: issue_rk};
        mq.push_back(wake(e));
      end
    end
  end

  always @(negedge clk) begin : compare
    int ld;
    if (!rst) begin
      chk("out_valid", out_valid, m_ov);
      chk("occupancy", occupancy, mq.size());
      if (m_ov) begin
        chk("out_vj", out_vj, m_out.vj);
        chk("out_vk", out_vk, m_out.vk);
        chk("out_imm", out_imm, m_out.imm);
        chk("out_pc", out_pc, m_out.pc);
        chk("out_op_robid", {out_op, out_robid}, {m_out.op, m_out.robid});
      end
      if (!flush) begin
        ld = (rdy && cand_idx() >= 0 && (!m_ov || out_ready)) ? 1 : 0;
        chk("next_full", next_full, (mq.size() + int'(issue_valid) - ld) >= D);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = '0;
    cdb_value   = '0;
    cdb_robid   = '0;
  endtask

  task automatic set_issue(input logic [RW-1:0] robid, input logic rj, input logic [RW-1:0] qj,
                           input logic [XL-1:0] vj, input logic rk, input logic [RW-1:0] qk,
                           input logic [XL-1:0] vk);
    issue_valid = 1'b1;
    issue_op    = OP_ADD;
    issue_robid = robid;
    issue_rj    = rj;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_rk    = rk;
    issue_qk    = qk;
    issue_vk    = vk;
    issue_imm   = {28'h0, robid} << 4;
    issue_pc    = 32'h1000 + ({28'h0, robid} << 2);
  endtask

  task automatic bcast(input int p, input logic [RW-1:0] tag, input logic [XL-1:0] v);
    cdb_valid[p]         = 1'b1;
    cdb_robid[p*RW +: RW] = tag;
    cdb_value[p*XL +: XL] = v;
  endtask

  logic [XL-1:0] held_vj;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_issue(0, 1, 0, 0, 1, 0, 0);
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_next_full", next_full, 0);
    chk("rst_out_vj", out_vj, 0);

    // 1: ready op dispatches one cycle after allocation
    set_issue(4'd7, 1, 0, 32'h11, 1, 0, 32'h22);
    tick();
    idle();
    chk("t1_occ_after_alloc", occupancy, 1);
    chk("t1_not_yet_valid", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_model_ov", m_ov, 1);
    chk("t1_out_vj", out_vj, 32'h11);
    chk("t1_out_vk", out_vk, 32'h22);
    chk("t1_out_robid", out_robid, 7);
    chk("t1_out_pc", out_pc, 32'h101c);
    chk("t1_occ_zero", occupancy, 0);
    tick();
    chk("t1_drained", out_valid, 0);

    // 2: wakeup via CDB port 1
    set_issue(4'd8, 0, 4'd3, 32'hdead, 1, 0, 32'h7);
    tick();
    idle();
    tick();
    bcast(1, 4'd3, 32'h55);
    tick();
    idle();
    chk("t2_no_dispatch_on_wake", out_valid, 0);
    tick();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_vj", out_vj, 32'h55);
    tick();

    // 3: issue bypass from CDB port 0
    set_issue(4'd9, 1, 0, 32'h3, 0, 4'd5, 32'hbeef);
    bcast(0, 4'd5, 32'ha0);
    tick();
    idle();
    chk("t3_occ", occupancy, 1);
    tick();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_vk", out_vk, 32'ha0);
    tick();

    // 4: back-pressure holds the oldest, then in-order drain
    out_ready = 1'b0;
    set_issue(4'd1, 1, 0, 32'ha, 1, 0, 0); tick();
    set_issue(4'd2, 1, 0, 32'hb, 1, 0, 0); tick();
    held_vj = out_vj;
    set_issue(4'd3, 1, 0, 32'hc, 1, 0, 0); tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_robid", out_robid, 1);
      chk("t4_hold_vj", out_vj, held_vj);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t4_second_B", out_robid, 2);
    tick();
    chk("t4_third_C", out_robid, 3);
    tick();
    chk("t4_empty", out_valid, 0);

    // 5: fill all entries with unready ops
    for (int i = 0; i < D; i++) begin
      set_issue(4'(i), 0, 4'(i), 0, 1, 0, 32'h5);
      #1;
      chk("t5_next_full_fill", next_full, i == D - 1);
      tick();
    end
    idle();
    #1;
    chk("t5_full_occ", occupancy, D);
    chk("t5_full_flag", next_full, 1);
    bcast(0, 4'd0, 32'h77);
    tick();
    idle();
    chk("t5_full_released", next_full, 0);
    tick();
    chk("t5_dispatch_vj", out_vj, 32'h77);
    chk("t5_occ_after", occupancy, D - 1);
    flush = 1'b1; tick(); flush = 1'b0;

    // 6: flush with busy entries and a stalled output
    out_ready = 1'b0;
    set_issue(4'd9, 1, 0, 32'h99, 1, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      set_issue(4'(i + 9), 0, 4'(i), 0, 1, 0, 0);
      tick();
    end
    idle();
    chk("t6_pre_occ", occupancy, 5);
    chk("t6_pre_valid", out_valid, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6_flush_occ", occupancy, 0);
    chk("t6_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bcast(0, 4'(i), 32'h1234);
      tick();
    end
    idle();
    tick();
    chk("t6_no_ghost_dispatch", out_valid, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rdy       = ($urandom % 10) != 0;
      flush     = ($urandom % 250) == 0;
      out_ready = ($urandom % 10) < 7;
      idle();
      for (int p = 0; p < NC; p++) begin
        if ($urandom % 2) bcast(p, 4'($urandom % 16), $urandom);
      end
      if (mq.size() < D && ($urandom % 2)) begin
        set_issue(4'($urandom % 16), 1'($urandom % 2), 4'($urandom % 16), $urandom,
                  1'($urandom % 2), 4'($urandom % 16), $urandom);
        issue_op  = 6'($urandom % 5);
        issue_imm = $urandom;
      end
      tick();
    end
    flush = 1'b0; rdy = 1'b1;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
